// File: rtl/iterative_muldiv.sv
// iterative_muldiv: RV32M/RV64M multiply/divide unit.
// Retires STEP bits per cycle behind valid/ready request/response handshakes.
module iterative_muldiv #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic [4:0]      res_rd,
  output logic            busy
);

  if ((STEP != 1 && STEP != 2 && STEP != 4) || (XLEN % STEP) != 0) begin : g_bad_step
    $error("iterative_muldiv: STEP must be 1, 2 or 4 and divide XLEN");
  end

  localparam int N  = XLEN / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [XLEN-1:0]   opa_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   rem_q;
  logic              res_valid_q;
  logic [XLEN-1:0]   res_data_q;
  logic [4:0]        res_rd_q;

  logic            s1, s2, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2;

  // Operand signedness, magnitudes and fast-path detection at acceptance
  always_comb begin
    s1 = req_rs1[XLEN-1] &&
         (req_op inside {3'b001, 3'b010, 3'b100, 3'b110});
    s2 = req_rs2[XLEN-1] &&
         (req_op inside {3'b001, 3'b100, 3'b110});
    mag1 = s1 ? -req_rs1 : req_rs1;
    mag2 = s2 ? -req_rs2 : req_rs2;
    div_zero = req_op[2] && (req_rs2 == '0);
    div_ovf  = req_op[2] && !req_op[0] &&
               (req_rs1 == MIN_NEG) && (&req_rs2);
  end

  logic [2*XLEN-1:0] mul_acc_d;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   div_quo_d, div_rem_d;
  logic [XLEN:0]     div_trial, div_diff;

  // One compute cycle: STEP shift-add or restoring-subtract steps
  always_comb begin
    mul_acc_d = acc_q;
    mul_sum   = '0;
    for (int i = 0; i < STEP; i++) begin
      mul_sum = {1'b0, mul_acc_d[2*XLEN-1:XLEN]} +
                (mul_acc_d[0] ? {1'b0, opa_q} : '0);
      mul_acc_d = {mul_sum, mul_acc_d[XLEN-1:1]};
    end
    div_rem_d = rem_q;
    div_quo_d = acc_q[XLEN-1:0];
    div_trial = '0;
    div_diff  = '0;
    for (int i = 0; i < STEP; i++) begin
      div_trial = {div_rem_d, div_quo_d[XLEN-1]};
      div_diff  = div_trial - {1'b0, opa_q};
      div_quo_d = {div_quo_d[XLEN-2:0], !div_diff[XLEN]};
      div_rem_d = div_diff[XLEN] ? div_trial[XLEN-1:0]
                                 : div_diff[XLEN-1:0];
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, res_d;

  // Sign correction and result selection for the FIX cycle
  always_comb begin
    prod  = neg_q ? -acc_q : acc_q;
    quo   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rmd   = neg_q ? -rem_q : rem_q;
    res_d = '0;
    unique case (1'b1)
      (op_q == 3'b000):               res_d = prod[XLEN-1:0];
      (!op_q[2] && op_q[1:0] != 0):   res_d = prod[2*XLEN-1:XLEN];
      (op_q[2] && !op_q[1]):          res_d = quo;
      (op_q[2] && op_q[1]):           res_d = rmd;
      default:                        res_d = '0;
    endcase
  end

  // Control FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      neg_q       <= 1'b0;
      opa_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_q  <= req_op;
            rd_q  <= req_rd;
            cnt_q <= CNT_N;
            if (div_zero) begin
              res_data_q  <= req_op[1] ? req_rs1 : '1;
              res_rd_q    <= req_rd;
              res_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (div_ovf) begin
              res_data_q  <= req_op[1] ? '0 : req_rs1;
              res_rd_q    <= req_rd;
              res_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (req_op[2]) begin
              opa_q   <= mag2;
              acc_q   <= {{XLEN{1'b0}}, mag1};
              rem_q   <= '0;
              neg_q   <= req_op[1] ? s1 : (s1 ^ s2);
              state_q <= S_DIV;
            end else begin
              opa_q   <= mag1;
              acc_q   <= {{XLEN{1'b0}}, mag2};
              neg_q   <= s1 ^ s2;
              state_q <= S_MUL;
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= S_FIX;
        end
        S_DIV: begin
          acc_q <= {acc_q[2*XLEN-1:XLEN], div_quo_d};
          rem_q <= div_rem_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= S_FIX;
        end
        S_FIX: begin
          res_data_q  <= res_d;
          res_rd_q    <= rd_q;
          res_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE) && !reset && !flush;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV) ||
                     (state_q == S_FIX);

endmodule
